mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter TIMEOUT, default 12'd4095, the maximum number of cycles a grant may remain busy before it is aborted.
REQ-002 Parameter MAX_WR_RUN, default 3'd4, the maximum number of consecutive write grants while rd_req is pending.
REQ-003 cmd_clk  in  1  single clock for all logic.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 calib_done  in  1  DRAM calibration complete.
REQ-006 wr_req0 / wr_req1  in  1 each  video input 0/1 holds at least one 64-word burst.
REQ-007 rd_req  in  1  display read path requests one burst.
REQ-008 rd_urgent  in  1  display FIFO is below its low-water mark.
REQ-009 wr_done / rd_done  in  1 each  one-cycle completion pulse from the write/read engine.
REQ-010 cmd_empty  in  1  controller command FIFO is empty.
REQ-011 arb_state  out  2  00 idle/drain, 01 read owner, 10 write owner, 11 unused.
REQ-012 wr_probe / rd_probe  out  1 each  level start request to the write/read engine.
REQ-013 sel  out  2  write source: 2'd1 = input 0, 2'd2 = input 1, 2'd0 = none.
REQ-014 timeout_err  out  1  sticky abort flag.
REQ-015 debug  out  8  {timeout_err, calib_done, rd_probe, wr_probe, sel[0], state[2:0]}.

Function
REQ-016 Internal states SHALL be IDLE, RD_BUSY, WR_BUSY and DRAIN; every output SHALL be registered.
REQ-017 In IDLE, with calib_done=1, the block SHALL pick one requester per cycle in this priority order: rd_urgent & rd_req, then write (round-robin), then rd_req.
- Exception: when wr_run==MAX_WR_RUN and rd_req=1, rd_req SHALL outrank the write requesters.
REQ-018 Round-robin: when both wr_req0 and wr_req1 are asserted, the input not granted last SHALL win; a lone requester SHALL win regardless of history.
REQ-019 last_wr SHALL reset to input 1, so the first contested grant goes to input 0.
REQ-020 Write grant: on the next edge, state=WR_BUSY, arb_state=10, sel=granted source, wr_probe=1.
- wr_run SHALL increment and saturate at MAX_WR_RUN.
REQ-021 Read grant: on the next edge, state=RD_BUSY, arb_state=01, rd_probe=1, sel=0, wr_run=0.
REQ-022 The probe and sel SHALL hold steady for the whole busy state.
REQ-023 Completion: on the edge that samples the matching done pulse, the probe SHALL clear, arb_state=00, sel=0 and state=DRAIN.
- A done pulse for the non-owning engine SHALL be ignored.
REQ-024 DRAIN SHALL last at least 1 cycle and SHALL exit to IDLE on the first cycle with cmd_empty=1.
- The minimum IDLE-to-IDLE grant cycle is therefore grant (1) + busy (at least 1) + drain (at least 1).
REQ-025 A busy counter (12 bits) SHALL clear on grant and increment each busy cycle.
- Abort: when the counter reaches TIMEOUT with no done, the block SHALL set timeout_err=1, clear the probe and sel, and enter DRAIN.
- timeout_err SHALL clear only on reset.
REQ-026 If done and timeout occur in the same cycle, done SHALL take precedence and timeout_err SHALL remain unchanged.
REQ-027 If calib_done=0 in any state, the next edge SHALL force state=IDLE with all probes, sel and arb_state at 0; wr_run, last_wr and timeout_err SHALL be kept.
REQ-028 Requests SHALL be sampled only in IDLE; requests that change while the block is busy or in DRAIN SHALL have no effect.
REQ-029 If no request is present in IDLE, the block SHALL stay in IDLE with all outputs at 0.

Reset
REQ-030 While rst_n=0, asynchronously: state=IDLE, arb_state=00, wr_probe=0, rd_probe=0, sel=0, timeout_err=0, wr_run=0, last_wr=1, busy counter=0.
REQ-031 Reset asserted mid-grant SHALL drop the probe immediately, without waiting for a clock edge.
REQ-032 After rst_n rises, the first grant SHALL be no earlier than the second cycle.

Verification
REQ-033 Contested writes: wr_req0=wr_req1=1 held, wr_done returned 5 cycles after each probe.
- Required: sel sequence 1,2,1,2; arb_state=10 while busy; arb_state=00 in the cycle after each wr_done.
REQ-034 Read fairness: wr_req0=1 and rd_req=1 held, rd_urgent=0, done pulses returned promptly.
- Required: exactly 4 write grants, then one read grant (rd_probe=1, arb_state=01), then writes resume.
REQ-035 Urgent read: rd_urgent=rd_req=1 asserted together with wr_req1=1.
- Required: the read is granted first; wr_probe stays 0 until rd_done, DRAIN and cmd_empty have completed.
REQ-036 Timeout: TIMEOUT=12'd20, write granted, no wr_done.
- Required: wr_probe falls exactly 20 busy cycles after the grant; timeout_err=1 and stays 1 through later grants.
REQ-037 Calibration loss: calib_done dropped during WR_BUSY.
- Required: on the next edge wr_probe=0, sel=0, arb_state=00; no grant until calib_done=1 again.
REQ-038 Async reset: rst_n pulsed low mid-cycle during RD_BUSY.
- Required: rd_probe=0 before the next edge; all outputs return to their reset values.

Source files
------------

// File: rtl/mem_arb.sv
// mem_arb: DRAM command arbiter sharing one controller between two video
// write inputs and a display read path. One grant at a time; each grant runs
// busy -> drain -> idle, with a watchdog abort and calibration gating.
module mem_arb #(
  parameter logic [11:0] TIMEOUT    = 12'd4095,
  parameter logic [2:0]  MAX_WR_RUN = 3'd4
) (
  input  logic       cmd_clk,
  input  logic       rst_n,
  input  logic       calib_done,
  input  logic       wr_req0,
  input  logic       wr_req1,
  input  logic       rd_req,
  input  logic       rd_urgent,
  input  logic       wr_done,
  input  logic       rd_done,
  input  logic       cmd_empty,
  output logic [1:0] arb_state,
  output logic       wr_probe,
  output logic       rd_probe,
  output logic [1:0] sel,
  output logic       timeout_err,
  output logic [7:0] debug
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_BUSY = 3'd1,
    WR_BUSY = 3'd2,
    DRAIN   = 3'd3
  } state_t;

  state_t      state, state_n;
  logic [1:0]  arb_state_n;
  logic [1:0]  sel_n;
  logic        wr_probe_n;
  logic        rd_probe_n;
  logic        timeout_err_n;
  logic [2:0]  wr_run, wr_run_n;
  logic        last_wr, last_wr_n;   // 0: input 0 granted last, 1: input 1
  logic [11:0] busy_cnt, busy_cnt_n;
  logic [11:0] busy_inc;
  logic        armed;                // blocks a grant on the first edge after reset
  logic        wr_any;
  logic        pick1;
  logic        rd_first;
  logic        busy_done;
  logic        timed_out;

  assign debug = {timeout_err, calib_done, rd_probe, wr_probe, sel[0], state};

  // Next-state and next-output decode; all outputs leave through registers.
  always_comb begin
    state_n       = state;
    arb_state_n   = arb_state;
    sel_n         = sel;
    wr_probe_n    = wr_probe;
    rd_probe_n    = rd_probe;
    timeout_err_n = timeout_err;
    wr_run_n      = wr_run;
    last_wr_n     = last_wr;
    busy_cnt_n    = busy_cnt;

    busy_inc  = busy_cnt + 12'd1;
    wr_any    = wr_req0 | wr_req1;
    // Contested writes go to the input that did not win last time.
    pick1     = wr_req1 & (~wr_req0 | ~last_wr);
    // Urgent reads, or reads starved by a full write run, beat the writers.
    rd_first  = rd_req & (rd_urgent | (wr_run >= MAX_WR_RUN));
    busy_done = (state == RD_BUSY) ? rd_done : wr_done;
    // Abort lands on the edge that would take the count to TIMEOUT, so the
    // probe is high for exactly TIMEOUT cycles.
    timed_out = (busy_inc == TIMEOUT);

    if (!calib_done) begin
      state_n     = IDLE;
      arb_state_n = '0;
      sel_n       = '0;
      wr_probe_n  = 1'b0;
      rd_probe_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (armed) begin
            if (rd_first || (!wr_any && rd_req)) begin
              state_n     = RD_BUSY;
              arb_state_n = 2'b01;
              rd_probe_n  = 1'b1;
              sel_n       = '0;
              wr_run_n    = '0;
              busy_cnt_n  = '0;
            end else if (wr_any) begin
              state_n     = WR_BUSY;
              arb_state_n = 2'b10;
              wr_probe_n  = 1'b1;
              sel_n       = pick1 ? 2'd2 : 2'd1;
              last_wr_n   = pick1;
              wr_run_n    = (wr_run >= MAX_WR_RUN) ? wr_run : wr_run + 3'd1;
              busy_cnt_n  = '0;
            end
          end
        end
        RD_BUSY, WR_BUSY: begin
          if (busy_done || timed_out) begin
            state_n     = DRAIN;
            arb_state_n = '0;
            sel_n       = '0;
            wr_probe_n  = 1'b0;
            rd_probe_n  = 1'b0;
            // A done in the same cycle as the abort wins; flag stays as is.
            if (!busy_done) timeout_err_n = 1'b1;
          end else begin
            busy_cnt_n = busy_inc;
          end
        end
        DRAIN: begin
          if (cmd_empty) state_n = IDLE;
        end
        default: begin
          state_n     = IDLE;
          arb_state_n = '0;
          sel_n       = '0;
          wr_probe_n  = 1'b0;
          rd_probe_n  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge cmd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      arb_state   <= '0;
      sel         <= '0;
      wr_probe    <= 1'b0;
      rd_probe    <= 1'b0;
      timeout_err <= 1'b0;
      wr_run      <= '0;
      last_wr     <= 1'b1;
      busy_cnt    <= '0;
      armed       <= 1'b0;
    end else begin
      state       <= state_n;
      arb_state   <= arb_state_n;
      sel         <= sel_n;
      wr_probe    <= wr_probe_n;
      rd_probe    <= rd_probe_n;
      timeout_err <= timeout_err_n;
      wr_run      <= wr_run_n;
      last_wr     <= last_wr_n;
      busy_cnt    <= busy_cnt_n;
      armed       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: scoreboard bench for mem_arb. The stimulus process predicts
// each grant from the arbitration rules and queues it; a monitor pops and
// compares whenever a probe rises.
module tb_mem_arb;

  localparam logic [11:0] TMO     = 12'd20;
  localparam int          MAX_RUN = 4;

  logic       cmd_clk;
  logic       rst_n;
  logic       calib_done;
  logic       wr_req0;
  logic       wr_req1;
  logic       rd_req;
  logic       rd_urgent;
  logic       wr_done;
  logic       rd_done;
  logic       cmd_empty;
  logic [1:0] arb_state;
  logic       wr_probe;
  logic       rd_probe;
  logic [1:0] sel;
  logic       timeout_err;
  logic [7:0] debug;

  mem_arb #(.TIMEOUT(TMO), .MAX_WR_RUN(3'd4)) dut (
    .cmd_clk(cmd_clk), .rst_n(rst_n), .calib_done(calib_done),
    .wr_req0(wr_req0), .wr_req1(wr_req1), .rd_req(rd_req),
    .rd_urgent(rd_urgent), .wr_done(wr_done), .rd_done(rd_done),
    .cmd_empty(cmd_empty), .arb_state(arb_state), .wr_probe(wr_probe),
    .rd_probe(rd_probe), .sel(sel), .timeout_err(timeout_err), .debug(debug)
  );

  typedef struct {
    bit         rd;
    logic [1:0] sel;
    int         cyc;
    bit         terr;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [2:0] idle_code;

  // Reference model state: which input won last, write run length, error flag.
  int m_last = 1;
  int m_run  = 0;
  bit m_terr = 0;

  initial begin
    cmd_clk = 0;
    forever #5 cmd_clk = ~cmd_clk;
  end

  always @(posedge cmd_clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Arbitration rules: urgent or starved read first, then round-robin writes, then read.
  task automatic predict(input bit w0, input bit w1, input bit r, input bit u,
                         output bit is_rd, output logic [1:0] s);
    int src;
    if ((r && (u || m_run == MAX_RUN)) || (!w0 && !w1 && r)) begin
      is_rd = 1;
      s     = 2'd0;
      m_run = 0;
    end else begin
      if (w0 && w1) src = 1 - m_last;
      else          src = w0 ? 0 : 1;
      is_rd  = 0;
      s      = (src == 0) ? 2'd1 : 2'd2;
      m_last = src;
      if (m_run < MAX_RUN) m_run++;
    end
  endtask

  task automatic garbage();
    wr_req0   = 1'($urandom_range(0, 1));
    wr_req1   = 1'($urandom_range(0, 1));
    rd_req    = 1'($urandom_range(0, 1));
    rd_urgent = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_gap(input int n);
    wr_req0 = 0; wr_req1 = 0; rd_req = 0; rd_urgent = 0;
    for (int j = 0; j < n; j++) begin
      @(negedge cmd_clk);
      chk("idle_quiet", {arb_state, sel, wr_probe, rd_probe}, 0);
    end
  endtask

  // One grant: drive requests at a negedge with the DUT idle, run the busy
  // phase (done after d cycles, d=0 means never), then k extra drain cycles.
  // abort_kind 1 drops calib_done, 2 pulses reset, at busy cycle abort_at.
  task automatic do_txn(input bit w0, input bit w1, input bit r, input bit u,
                        input int d, input int k, input bit hold, input int lat,
                        input int abort_kind, input int abort_at);
    exp_t       e;
    bit         is_rd;
    logic [1:0] es;
    logic [1:0] earb;
    int         waited;
    int         blen;
    wr_req0 = w0; wr_req1 = w1; rd_req = r; rd_urgent = u;
    wr_done = 0; rd_done = 0;
    predict(w0, w1, r, u, is_rd, es);
    e.rd = is_rd; e.sel = es; e.cyc = cyc + lat; e.terr = m_terr;
    sb.push_back(e);
    waited = 0;
    do begin
      @(negedge cmd_clk);
      waited++;
    end while (!(wr_probe | rd_probe) && waited < 6);
    if (!(wr_probe | rd_probe)) begin
      chk("grant_wait", wr_probe | rd_probe, 1);
      return;
    end
    earb = is_rd ? 2'b01 : 2'b10;
    blen = (d == 0) ? int'(TMO) : d;
    for (int j = 1; j <= blen; j++) begin
      chk("busy_probe", is_rd ? rd_probe : wr_probe, 1);
      chk("busy_other", is_rd ? wr_probe : rd_probe, 0);
      chk("busy_arb", arb_state, earb);
      chk("busy_sel", sel, es);
      if (!hold) garbage();
      cmd_empty = 1'($urandom_range(0, 1));
      wr_done = 0; rd_done = 0;
      if (abort_kind == 1 && j == abort_at) begin
        calib_done = 0;
        @(negedge cmd_clk);
        chk("calib_drop", {arb_state, sel, wr_probe, rd_probe}, 0);
        chk("calib_terr", timeout_err, m_terr);
        wr_req0 = 1; rd_req = 1; rd_urgent = 1;
        repeat (3) begin
          @(negedge cmd_clk);
          chk("calib_hold", {arb_state, sel, wr_probe, rd_probe}, 0);
        end
        return;
      end
      if (abort_kind == 2 && j == abort_at) begin
        #2 rst_n = 0;
        #1 chk("async_probe", wr_probe | rd_probe, 0);
        chk("async_out", {arb_state, sel, timeout_err}, 0);
        chk("async_debug", debug[7:3], {1'b0, calib_done, 3'b000});
        m_last = 1; m_run = 0; m_terr = 0;
        repeat (2) @(negedge cmd_clk);
        return;
      end
      if (j == d) begin
        if (is_rd) rd_done = 1; else wr_done = 1;
      end else if ($urandom_range(0, 3) == 0) begin
        if (is_rd) wr_done = 1; else rd_done = 1;
      end
      @(negedge cmd_clk);
    end
    wr_done = 0; rd_done = 0;
    if (d == 0) m_terr = 1;
    chk("end_probe", wr_probe | rd_probe, 0);
    chk("end_arb_sel", {arb_state, sel}, 0);
    chk("end_terr", timeout_err, m_terr);
    for (int j = 0; j < k; j++) begin
      cmd_empty = 0;
      if (!hold) garbage();
      @(negedge cmd_clk);
      chk("drain_quiet", {arb_state, sel, wr_probe, rd_probe}, 0);
    end
    cmd_empty = 1;
    @(negedge cmd_clk);
    chk("drain_exit_quiet", {arb_state, sel, wr_probe, rd_probe}, 0);
  endtask

  task automatic rand_txns(input int n);
    bit w0, w1, r, u;
    for (int i = 0; i < n; i++) begin
      do begin
        w0 = 1'($urandom_range(0, 1));
        w1 = 1'($urandom_range(0, 1));
        r  = 1'($urandom_range(0, 1));
        u  = 1'($urandom_range(0, 1));
      end while (!(w0 | w1 | r));
      if ($urandom_range(0, 3) == 0) idle_gap(int'($urandom_range(1, 3)));
      do_txn(w0, w1, r, u, int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1, 0, 0);
    end
  endtask

  // Monitor: every rising probe must match the oldest predicted grant.
  initial begin : monitor
    bit   prev;
    bit   cur;
    exp_t e;
    prev = 0;
    forever begin
      @(negedge cmd_clk);
      cur = wr_probe | rd_probe;
      if (rst_n && cur && !prev) begin
        if (sb.size() == 0) begin
          chk("grant_unexpected", cur, 0);
        end else begin
          e = sb.pop_front();
          chk("grant_rd", rd_probe, e.rd);
          chk("grant_wr", wr_probe, !e.rd);
          chk("grant_sel", sel, e.sel);
          chk("grant_arb", arb_state, e.rd ? 2'b01 : 2'b10);
          chk("grant_cycle", cyc, e.cyc);
          chk("grant_terr", timeout_err, e.terr);
          chk("grant_debug", debug[7:3], {e.terr, 1'b1, e.rd, !e.rd, e.sel[0]});
          chk("grant_debug_state", debug[2:0] != idle_code, 1);
        end
      end
      prev = cur;
    end
  end

  // Directed scenarios first, then randomized traffic, then reset mid-read.
  initial begin : stim
    rst_n = 0; calib_done = 1; cmd_empty = 1;
    wr_req0 = 0; wr_req1 = 0; rd_req = 0; rd_urgent = 0;
    wr_done = 0; rd_done = 0;
    repeat (3) @(negedge cmd_clk);
    chk("rst_out", {arb_state, sel, wr_probe, rd_probe, timeout_err}, 0);
    chk("rst_debug", debug[7:3], {1'b0, 1'b1, 3'b000});
    idle_code = debug[2:0];
    rst_n = 1;
    // Contested writes, first grant held off one extra cycle after reset.
    do_txn(1, 1, 0, 0, 5, 0, 1, 2, 0, 0);
    repeat (3) do_txn(1, 1, 0, 0, 5, 0, 1, 1, 0, 0);
    idle_gap(2);
    // Urgent read ahead of a pending write.
    do_txn(0, 1, 1, 1, 3, 2, 1, 1, 0, 0);
    // Read fairness: four writes, one read, writes resume.
    repeat (6) do_txn(1, 0, 1, 0, 1, 0, 1, 1, 0, 0);
    idle_gap(1);
    // Done coincides with the timeout cycle, then a real timeout.
    do_txn(0, 1, 0, 0, 20, 1, 0, 1, 0, 0);
    do_txn(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    do_txn(0, 1, 1, 0, 2, 0, 0, 1, 0, 0);
    // Calibration loss during a write.
    do_txn(1, 1, 0, 0, 4, 0, 1, 1, 1, 2);
    calib_done = 1;
    do_txn(1, 1, 0, 0, 2, 0, 1, 1, 0, 0);
    rand_txns(50);
    idle_gap(1);
    // Asynchronous reset in the middle of a read.
    do_txn(0, 0, 1, 0, 5, 0, 1, 1, 2, 2);
    rst_n = 1;
    do_txn(1, 0, 1, 1, 2, 1, 0, 2, 0, 0);
    rand_txns(5);
    idle_gap(2);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
